// File: rtl/load_pkg.sv
// Shared definitions for the RV32I data-memory load path:
// funct3 codes, FSM state encoding, error codes and decode helpers.
package load_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_FUNCT3   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  function automatic logic f3_legal(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  // Only meaningful for legal funct3 values; byte loads never misalign.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lane);
    logic mis;
    mis = 1'b0;
    if ((f3 == F3_LH) || (f3 == F3_LHU)) mis = lane[0];
    else if (f3 == F3_LW)                mis = (lane != 2'b00);
    return mis;
  endfunction

endpackage

// File: rtl/load_extract.sv
// Selects the addressed byte/halfword/word from a little-endian read word
// and applies zero or sign extension according to funct3.
module load_extract
  import load_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word[{lane, 3'b000} +: 8];
    half_v = word[{lane[1], 4'b0000} +: 16];
    case (funct3)
      F3_LB:   result = {{24{byte_v[7]}}, byte_v};
      F3_LH:   result = {{16{half_v[15]}}, half_v};
      F3_LBU:  result = {24'h000000, byte_v};
      F3_LHU:  result = {16'h0000, half_v};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// Sequential load unit: one word-aligned read per accepted load, with
// extraction/extension of the result and error reporting via a done pulse.
module load_unit
  import load_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic [2:0]  funct3,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic [1:0]  err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output state_t      dbg_state
);

  // Memory handshake: mem_req is held with a stable mem_addr until a cycle in
  // which mem_ack is high; that edge completes the transfer and drops mem_req.
  // mem_ack outside REQ is ignored.
  localparam logic [7:0] TLIM = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [7:0]  tcnt;
  logic [1:0]  lane_q;
  logic [2:0]  f3_q;
  logic [31:0] ext_data;

  load_extract u_extract (
    .word   (mem_rdata),
    .lane   (lane_q),
    .funct3 (f3_q),
    .result (ext_data)
  );

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      mem_req  <= 1'b0;
      rdata    <= 32'h0;
      err      <= ERR_OK;
      mem_addr <= 32'h0;
      tcnt     <= 8'h0;
      lane_q   <= 2'b00;
      f3_q     <= 3'b000;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            lane_q   <= addr[1:0];
            f3_q     <= funct3;
            mem_addr <= {addr[31:2], 2'b00};
            tcnt     <= 8'h0;
            busy     <= 1'b1;
            if (!f3_legal(funct3)) begin
              state <= S_RESP;
              done  <= 1'b1;
              err   <= ERR_FUNCT3;
              rdata <= 32'h0;
            end else if (is_misaligned(funct3, addr[1:0])) begin
              state <= S_RESP;
              done  <= 1'b1;
              err   <= ERR_MISALIGN;
              rdata <= 32'h0;
            end else begin
              state   <= S_REQ;
              mem_req <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            state   <= S_RESP;
            mem_req <= 1'b0;
            done    <= 1'b1;
            rdata   <= ext_data;
            err     <= ERR_OK;
          end else if (tcnt == TLIM) begin
            state   <= S_RESP;
            mem_req <= 1'b0;
            done    <= 1'b1;
            rdata   <= 32'h0;
            err     <= ERR_TIMEOUT;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state   <= S_IDLE;
          busy    <= 1'b0;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit: hand-computed loads, error paths, timeout,
// late ack, mid-request reset and start-while-busy.
module tb_load_unit;
  import load_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [2:0]  funct3 = 3'b000;
  logic        busy, done, mem_req;
  logic [31:0] rdata, mem_addr;
  logic [1:0]  err;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  state_t      dbg_state;

  int n_checks = 0;
  int n_pass = 0;

  load_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .addr      (addr),
    .funct3    (funct3),
    .busy      (busy),
    .done      (done),
    .rdata     (rdata),
    .err       (err),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one load in the current (IDLE) cycle and services the memory side.
  // ack_at: REQ cycle index (0 = first) on which mem_ack is given, -1 = never.
  task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input int ack_at, input logic [31:0] word,
                          input logic [31:0] exp_data, input logic [1:0] exp_err,
                          input int exp_lat, input int exp_req, input bit poke);
    int req_cycles;
    int done_cycle;
    int cyc;
    req_cycles = 0;
    done_cycle = -1;
    start  = 1'b1;
    addr   = a;
    funct3 = f3;
    step();
    start = 1'b0;
    cyc = 1;
    while (done_cycle < 0 && cyc <= 40) begin
      mem_ack   = 1'b0;
      mem_rdata = $urandom();
      if (poke && busy) begin
        start  = 1'b1;
        addr   = 32'h0000_0555;
        funct3 = 3'b000;
      end
      if (done) begin
        done_cycle = cyc;
        start = 1'b0;
      end else begin
        if (mem_req) begin
          check({tag, "_maddr"}, mem_addr, {a[31:2], 2'b00});
          if (req_cycles == ack_at) begin
            mem_ack   = 1'b1;
            mem_rdata = word;
          end
          req_cycles++;
        end
        step();
        cyc++;
      end
    end
    start = 1'b0;
    check({tag, "_lat"}, 32'(done_cycle), 32'(exp_lat));
    check({tag, "_reqcyc"}, 32'(req_cycles), 32'(exp_req));
    check({tag, "_rdata"}, rdata, exp_data);
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_req_off"}, 32'(mem_req), 32'd0);
    step();
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_hold"}, rdata, exp_data);
  endtask

  initial begin
    step();
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_maddr", mem_addr, 32'h0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    reset = 1'b0;
    step();

    run_load("lw",    F3_LW,  32'h100, 0, 32'hDEADBEEF, 32'hDEADBEEF, ERR_OK, 2, 1, 1'b0);
    run_load("lb",    F3_LB,  32'h103, 1, 32'h80123456, 32'hFFFFFF80, ERR_OK, 3, 2, 1'b0);
    run_load("lbu",   F3_LBU, 32'h103, 0, 32'h80123456, 32'h00000080, ERR_OK, 2, 1, 1'b0);
    run_load("lh",    F3_LH,  32'h202, 2, 32'h8001ABCD, 32'hFFFF8001, ERR_OK, 4, 3, 1'b0);
    run_load("lhu",   F3_LHU, 32'h200, 0, 32'h8001ABCD, 32'h0000ABCD, ERR_OK, 2, 1, 1'b0);
    run_load("lb1",   F3_LB,  32'h101, 0, 32'h0000F700, 32'hFFFFFFF7, ERR_OK, 2, 1, 1'b0);
    run_load("lbu1",  F3_LBU, 32'h101, 0, 32'h0000F700, 32'h000000F7, ERR_OK, 2, 1, 1'b0);
    run_load("lhpos", F3_LH,  32'h200, 0, 32'h00007FFF, 32'h00007FFF, ERR_OK, 2, 1, 1'b0);
    run_load("lh_mis", F3_LH, 32'h101, 0, 32'h12345678, 32'h0, ERR_MISALIGN, 1, 0, 1'b0);
    run_load("lw_pre", F3_LW, 32'h104, 0, 32'hCAFEF00D, 32'hCAFEF00D, ERR_OK, 2, 1, 1'b0);
    run_load("lw_mis", F3_LW, 32'h102, 0, 32'h12345678, 32'h0, ERR_MISALIGN, 1, 0, 1'b0);
    run_load("f3_011", 3'b011, 32'h101, 0, 32'h12345678, 32'h0, ERR_FUNCT3, 1, 0, 1'b0);
    run_load("f3_111", 3'b111, 32'h100, 0, 32'h12345678, 32'h0, ERR_FUNCT3, 1, 0, 1'b0);

    run_load("lw_pre2", F3_LW, 32'h108, 0, 32'h11223344, 32'h11223344, ERR_OK, 2, 1, 1'b0);
    run_load("tmo",     F3_LW, 32'h40, -1, 32'h0, 32'h0, ERR_TIMEOUT, 17, 16, 1'b0);
    // Late ack two cycles after the timeout done pulse.
    step();
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFFFFFF;
    step();
    mem_ack = 1'b0;
    check("late_done", 32'(done), 32'd0);
    check("late_busy", 32'(busy), 32'd0);
    check("late_rdata", rdata, 32'h0);
    check("late_err", 32'(err), 32'(ERR_TIMEOUT));
    step();
    check("late_done2", 32'(done), 32'd0);

    run_load("poke", F3_LHU, 32'h302, 2, 32'hBEEF1234, 32'h0000BEEF, ERR_OK, 4, 3, 1'b1);
    run_load("poke_e", F3_LH, 32'h303, 0, 32'h0, 32'h0, ERR_MISALIGN, 1, 0, 1'b1);

    // Reset on the third REQ cycle abandons the request.
    run_load("lw_pre3", F3_LW, 32'h10C, 0, 32'h55AA55AA, 32'h55AA55AA, ERR_OK, 2, 1, 1'b0);
    start  = 1'b1;
    addr   = 32'h500;
    funct3 = F3_LW;
    step();
    start = 1'b0;
    step();
    step();
    check("rst3_req", 32'(mem_req), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst3_req_off", 32'(mem_req), 32'd0);
    check("rst3_busy", 32'(busy), 32'd0);
    check("rst3_done", 32'(done), 32'd0);
    check("rst3_rdata", rdata, 32'h0);
    check("rst3_maddr", mem_addr, 32'h0);
    mem_ack   = 1'b1;
    mem_rdata = 32'h87654321;
    step();
    mem_ack = 1'b0;
    check("rst3_ack_done", 32'(done), 32'd0);
    check("rst3_ack_busy", 32'(busy), 32'd0);
    check("rst3_ack_rdata", rdata, 32'h0);

    run_load("after_rst", F3_LB, 32'h502, 0, 32'h00FE0000, 32'hFFFFFFFE, ERR_OK, 2, 1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/load_unit.md
Name: load_unit

Overview:
- Sequential load path for the RV32I core's data memory.
- Accepts a load command from the execute stage and issues a single word-aligned read request on the data-memory handshake.
- Extracts the addressed byte, halfword or word from the returned data, then zero- or sign-extends it.
- Returns the result with a one-cycle done pulse and reports misalignment, illegal funct3 and memory timeout as error codes.

Parameters:
- TIMEOUT_CYCLES, 16: maximum number of cycles mem_req is held waiting for mem_ack. Legal range 1..255.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  load command valid; sampled only in IDLE.
- addr  input  32  byte address of the load.
- funct3  input  3  RV32I load funct3 (LB=000, LH=001, LW=010, LBU=100, LHU=101).
- busy  output  1  high in REQ and RESP.
- done  output  1  one-cycle pulse; rdata and err are valid in this cycle.
- rdata  output  32  extended load result; holds its value until the next accepted start.
- err  output  2  00 ok, 01 misaligned, 10 illegal funct3, 11 timeout; held alongside rdata.
- mem_req  output  1  read request to data memory.
- mem_addr  output  32  {addr[31:2], 2'b00}; stable while mem_req is high.
- mem_ack  input  1  memory has valid mem_rdata this cycle.
- mem_rdata  input  32  little-endian read word.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset); the polarity and synchronicity are fixed.
- Reset: state goes to IDLE. busy, done, mem_req, rdata, err, mem_addr and the timeout counter are all cleared to 0.
- Reset wins over every other input in the same edge, including mid-REQ; an in-flight request is abandoned and a later mem_ack is ignored.
- States: IDLE, REQ, RESP.
- IDLE, start=1:
  - Latch addr and funct3.
  - Illegal funct3 (011, 110, 111) -> RESP with err=10; no memory request is made.
  - Otherwise misaligned (LH/LHU with addr[0]=1, or LW with addr[1:0]!=00) -> RESP with err=01; no memory request is made.
  - Otherwise -> REQ and clear the timeout counter.
  - Illegal funct3 takes priority over misalignment.
- REQ:
  - mem_req=1.
  - A mem_ack sampled in any REQ cycle, including the first, captures mem_rdata and moves to RESP with err=00.
  - Otherwise the counter increments. After TIMEOUT_CYCLES REQ cycles with no ack, move to RESP with err=11 and rdata=0.
- RESP: done=1 for exactly one cycle, then IDLE. busy is still high during RESP.
- start is ignored while busy.
- mem_ack is ignored in IDLE and RESP, including a late ack after a timeout.
- Latency: start accepted at cycle 0 -> mem_req high from cycle 1 -> ack at cycle k (k>=1) -> done at cycle k+1. Minimum 2 cycles. Error-without-request paths assert done at cycle 1.
- Extraction, with lane=addr[1:0]:
  - byte = mem_rdata[8*lane+7 : 8*lane].
  - half = mem_rdata[16*addr[1]+15 : 16*addr[1]].
  - LB and LH sign-extend from bit 7 / bit 15.
  - LBU and LHU zero-extend (result masked with 0x000000FF / 0x0000FFFF).
  - LW passes the word through.
- On any error, rdata=0.
- Back-to-back loads: the earliest new start is accepted in the IDLE cycle following done, so the minimum issue interval is 3 cycles.

Decomposition:
- Shared package load_pkg:
  - funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU).
  - State encoding (S_IDLE, S_REQ, S_RESP).
  - Error codes (ERR_OK, ERR_MISALIGN, ERR_FUNCT3, ERR_TIMEOUT).
- One combinational sub-module load_extract: inputs word, lane[1:0] and funct3; output is the extended 32-bit result. Instantiated once, driven by the latched addr/funct3 and mem_rdata.

Test Plan:
- LW at addr=0x100, mem_ack on the first REQ cycle with mem_rdata=0xDEADBEEF -> mem_addr=0x100, done at cycle 2, rdata=0xDEADBEEF, err=00.
- LB at addr=0x103, mem_rdata=0x80123456 -> rdata=0xFFFFFF80. LBU at the same address and data -> rdata=0x00000080.
- LH at addr=0x202, mem_rdata=0x8001ABCD -> rdata=0xFFFF8001. LHU at addr=0x200 -> rdata=0x0000ABCD.
- LH at addr=0x101 -> mem_req never asserted, done at cycle 1, err=01, rdata=0. funct3=011 at addr=0x101 -> err=10.
- LW with no mem_ack, TIMEOUT_CYCLES=16 -> mem_req high for exactly 16 cycles, then done with err=11. A mem_ack arriving 2 cycles later causes no done and no rdata change.
- reset asserted on the 3rd REQ cycle -> mem_req=0 and busy=0 on the next edge, no done pulse. A start pulsed during REQ/RESP is ignored, and a new start after IDLE is accepted normally.
